// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage for the single-cycle MIPS R3000 core: owns the PC,
// fetches over a req/ready handshake, issues one instruction and computes the next PC.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic        instr_valid_o,
  input  logic        retire_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        halted_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        misaligned;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        fault;
  logic        halt_word;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Redirect priority: JR overrides J, which overrides a taken branch.
  always_comb begin
    if (jr_i)                next_pc = jr_target_i;
    else if (jump_i)         next_pc = jump_target;
    else if (branch_taken_i) next_pc = branch_target;
    else                     next_pc = pc_plus4;
  end

  assign fault     = (next_pc[1:0] != 2'b00);
  assign halt_word = (imem_data_i[31:26] == 6'h3F);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (imem_ready_i) state_next = halt_word ? S_HALT : S_ISSUE;
      S_ISSUE: if (retire_i)     state_next = fault ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc         <= RESET_PC;
      instr      <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      if (state == S_FETCH && imem_ready_i) instr <= imem_data_i;
      // A faulting redirect leaves the PC pointing at the offending instruction.
      if (state == S_ISSUE && retire_i) begin
        if (fault) misaligned <= 1'b1;
        else       pc         <= next_pc;
      end
    end
  end

  assign imem_req_o    = (state == S_FETCH);
  assign instr_valid_o = (state == S_ISSUE);
  assign halted_o      = (state == S_HALT);
  assign misaligned_o  = misaligned;
  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign pc_plus4_o    = pc_plus4;
  assign instr_o       = instr;
  assign instr_op_o    = instr[31:26];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: an abstract phase/PC model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ADDI     = 32'h2008_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [5:0]  instr_op_o;
  logic        instr_valid_o;
  logic        retire_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        jump_i = 1'b0;
  logic        jr_i = 1'b0;
  logic [31:0] jr_target_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        halted_o;
  logic        misaligned_o;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ready_i   (imem_ready_i),
    .imem_data_i    (imem_data_i),
    .instr_o        (instr_o),
    .instr_op_o     (instr_op_o),
    .instr_valid_o  (instr_valid_o),
    .retire_i       (retire_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .jr_i           (jr_i),
    .jr_target_i    (jr_target_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .halted_o       (halted_o),
    .misaligned_o   (misaligned_o)
  );

  // Sparse instruction memory; unwritten words read as ADDI.
  logic [31:0] mem [logic [31:0]];
  int          mem_gen = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ADDI;
  endfunction

  always @(imem_addr_o or mem_gen) imem_data_i = mem_word(imem_addr_o);

  task automatic set_mem(input logic [31:0] a, input logic [31:0] w);
    mem[a] = w;
    mem_gen++;
  endtask

  task automatic clear_mem();
    mem.delete();
    mem_gen++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Abstract model: which phase the unit is in, which PC it holds, which word it issued.
  typedef enum {P_IDLE, P_FETCH, P_ISSUE, P_HALT} phase_t;
  phase_t      m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_mis;

  function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                                input logic j_r, input logic j, input logic br,
                                                input logic [31:0] tgt);
    logic [31:0]        seq;
    logic signed [31:0] off;
    seq = pc + 32'd4;
    off = $signed(ins[15:0]);
    if (j_r) return tgt;
    if (j)   return {seq[31:28], ins[25:0], 2'b00};
    if (br)  return seq + 32'(off * 4);
    return seq;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE;
      m_pc    <= RESET_PC;
      m_instr <= 32'h0;
      m_mis   <= 1'b0;
    end else begin
      case (m_phase)
        P_IDLE:  m_phase <= P_FETCH;
        P_FETCH: if (imem_ready_i) begin
          m_instr <= mem_word(m_pc);
          m_phase <= ((mem_word(m_pc) >> 26) == 32'h3F) ? P_HALT : P_ISSUE;
        end
        P_ISSUE: if (retire_i) begin
          if (model_next_pc(m_pc, m_instr, jr_i, jump_i, branch_taken_i, jr_target_i) % 4 != 0) begin
            m_mis   <= 1'b1;
            m_phase <= P_HALT;
          end else begin
            m_pc    <= model_next_pc(m_pc, m_instr, jr_i, jump_i, branch_taken_i, jr_target_i);
            m_phase <= P_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("req",        imem_req_o,    m_phase == P_FETCH);
      check("valid",      instr_valid_o, m_phase == P_ISSUE);
      check("halted",     halted_o,      m_phase == P_HALT);
      check("misaligned", misaligned_o,  m_mis);
      check("addr",       imem_addr_o,   m_pc);
      check("pc",         pc_o,          m_pc);
      check("pc_plus4",   pc_plus4_o,    m_pc + 32'd4);
      check("instr",      instr_o,       m_instr);
      check("instr_op",   instr_op_o,    m_instr[31:26]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    jr_i = 0; jump_i = 0; branch_taken_i = 0; jr_target_i = 0;
    imem_ready_i = 1; retire_i = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic wait_fetch(input string name, input logic [31:0] exp);
    for (int i = 0; i < 40 && !(imem_req_o && imem_addr_o == exp); i++) tick();
    check({name, "_req"},  imem_req_o,  1'b1);
    check({name, "_addr"}, imem_addr_o, exp);
  endtask

  task automatic step(input logic s_jr, input logic s_j, input logic s_br, input logic [31:0] tgt);
    for (int i = 0; i < 40 && !instr_valid_o; i++) tick();
    check("step_valid", instr_valid_o, 1'b1);
    jr_i = s_jr; jump_i = s_j; branch_taken_i = s_br; jr_target_i = tgt;
    retire_i = 1;
    tick();
    jr_i = 0; jump_i = 0; branch_taken_i = 0; jr_target_i = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          req_cnt;
    int          valid_cnt;
    #2;
    rst = 1;
    cmp_en = 1;

    // Reset values and sequential flow.
    clear_mem();
    set_mem(32'h40,  32'h1000_FFFE);
    set_mem(32'h100, 32'h0800_0080);
    set_mem(32'h84,  32'h2129_0005);
    jr_i = 0; jump_i = 0; branch_taken_i = 0; jr_target_i = 0;
    imem_ready_i = 1; retire_i = 1;
    tick();
    tick();
    check("rst_pc",       pc_o,          32'h0);
    check("rst_pc4",      pc_plus4_o,    32'h4);
    check("rst_instr",    instr_o,       32'h0);
    check("rst_req",      imem_req_o,    1'b0);
    check("rst_valid",    instr_valid_o, 1'b0);
    check("rst_halted",   halted_o,      1'b0);
    check("rst_mis",      misaligned_o,  1'b0);
    rst = 0;
    check("idle_req",     imem_req_o,    1'b0);
    tick();
    check("seq0_req",     imem_req_o,    1'b1);
    check("seq0_addr",    imem_addr_o,   32'h0);
    tick();
    check("seq0_valid",   instr_valid_o, 1'b1);
    check("seq0_instr",   instr_o,       ADDI);
    check("seq0_noreq",   imem_req_o,    1'b0);
    tick();
    check("seq4_addr",    imem_addr_o,   32'h4);
    check("seq4_req",     imem_req_o,    1'b1);
    tick();
    check("seq4_valid",   instr_valid_o, 1'b1);
    tick();
    check("seq8_addr",    imem_addr_o,   32'h8);

    // Branch, jump and JR priority.
    step(1, 0, 0, 32'h40);
    wait_fetch("jr40", 32'h40);
    step(0, 0, 1, 32'h0);
    wait_fetch("beq", 32'h3C);
    step(1, 0, 0, 32'h100);
    wait_fetch("jr100", 32'h100);
    step(0, 1, 0, 32'h0);
    wait_fetch("jump", 32'h200);
    step(1, 0, 1, 32'h80);
    wait_fetch("jr_over_br", 32'h80);

    // Stalls: three memory wait cycles, then two retire wait cycles.
    tick();
    check("stall_issue80", instr_valid_o, 1'b1);
    imem_ready_i = 0;
    retire_i = 1;
    tick();
    retire_i = 0;
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (imem_req_o) req_cnt++;
      tick();
    end
    imem_ready_i = 1;
    if (imem_req_o) req_cnt++;
    tick();
    check("stall_req_cycles", 32'(req_cnt), 32'd4);
    valid_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      if (instr_valid_o) valid_cnt++;
      check("stall_instr", instr_o, 32'h2129_0005);
      tick();
    end
    retire_i = 1;
    if (instr_valid_o) valid_cnt++;
    check("stall_instr", instr_o, 32'h2129_0005);
    tick();
    check("stall_valid_cycles", 32'(valid_cnt), 32'd3);
    check("stall_next_addr", imem_addr_o, 32'h88);

    // HALT word at 0xC.
    clear_mem();
    set_mem(32'hC, 32'hFC00_0000);
    do_reset();
    wait_fetch("halt_fetch", 32'hC);
    tick();
    check("halt_halted", halted_o,      1'b1);
    check("halt_valid",  instr_valid_o, 1'b0);
    check("halt_op",     instr_op_o,    6'h3F);
    imem_ready_i = 1; retire_i = 1; jr_i = 1; jr_target_i = 32'h40;
    tick();
    imem_ready_i = 0; retire_i = 0;
    tick();
    imem_ready_i = 1; retire_i = 1;
    tick();
    jr_i = 0; jr_target_i = 0;
    check("halt_pc_frozen", pc_o,       32'hC);
    check("halt_sticky",    halted_o,   1'b1);
    check("halt_noreq",     imem_req_o, 1'b0);

    // Misaligned JR target.
    clear_mem();
    do_reset();
    wait_fetch("fault_fetch", 32'h0);
    step(1, 0, 0, 32'h102);
    check("fault_mis",    misaligned_o, 1'b1);
    check("fault_halted", halted_o,     1'b1);
    check("fault_pc",     pc_o,         32'h0);
    tick();
    tick();
    check("fault_sticky", misaligned_o, 1'b1);

    // PC wrap at the top of the address space.
    do_reset();
    step(1, 0, 0, 32'hFFFF_FFFC);
    wait_fetch("wrap_top", 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4_o, 32'h0);
    step(0, 0, 0, 32'h0);
    wait_fetch("wrap_zero", 32'h0);

    // Reset asserted mid-ISSUE.
    tick();
    check("midrst_pre_valid", instr_valid_o, 1'b1);
    rst = 1;
    #1;
    check("midrst_valid", instr_valid_o, 1'b0);
    check("midrst_pc",    pc_o,          RESET_PC);
    check("midrst_req",   imem_req_o,    1'b0);
    tick();
    rst = 0;
    check("midrst_idle", imem_req_o, 1'b0);
    tick();
    check("midrst_refetch_req",  imem_req_o,  1'b1);
    check("midrst_refetch_addr", imem_addr_o, RESET_PC);
    tick();
    tick();

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
